// File: rtl/lcd_bus_receiver.sv
// HD44780-style LCD bus monitor: rebuilds bytes from E falling edges, decodes the core
// instruction set and keeps a 2x16 DDRAM shadow. Optional counters: LCD_RX_STATS_EN.
module lcd_bus_receiver #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CLEAR_CHAR  = 8'h20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic         lcd_e,
  input  logic         lcd_4,
  input  logic         lcd_5,
  input  logic         lcd_6,
  input  logic         lcd_7,
  output logic [255:0] chars,
  output logic         byte_valid,
  output logic [7:0]   byte_out,
  output logic         byte_rs,
  output logic         four_bit,
  output logic         display_on,
  output logic [15:0]  cmd_count,
  output logic [15:0]  data_count
);

  // Bus sample layout: [6]=RS [5]=RW [4]=E [3:0]=D7..D4
  logic [6:0]   sync_r [SYNC_STAGES];
  logic [6:0]   samp_r;
  logic         prev_e_r;

  logic [255:0] chars_r;
  logic         byte_valid_r;
  logic [7:0]   byte_out_r;
  logic         byte_rs_r;
  logic         four_bit_r;
  logic         display_on_r;
  logic [6:0]   ac_r;
  logic         id_r;
  logic         phase_lo_r;
  logic [3:0]   hi_nib_r;

  logic         strobe_s;
  logic         rs_s;
  logic         rw_s;
  logic [3:0]   nib_s;
  logic [7:0]   byte_s;
  logic         byte_done_s;
  logic [6:0]   ac_nx_s;
  logic         in_win_s;
  logic [4:0]   idx_s;
  logic [255:0] chars_wr_s;

  // Two-line address counter step with the 0x27<->0x40 and 0x67<->0x00 wraps
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (ac == 7'h27)      r = 7'h40;
      else if (ac == 7'h67) r = 7'h00;
      else                  r = ac + 7'd1;
    end else begin
      if (ac == 7'h40)      r = 7'h27;
      else if (ac == 7'h00) r = 7'h67;
      else                  r = ac - 7'd1;
    end
    return r;
  endfunction

  // Input synchronizer chain, extra sample register and previous-E register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= 7'd0;
      samp_r   <= 7'd0;
      prev_e_r <= 1'b0;
    end else begin
      sync_r[0] <= {lcd_rs, lcd_rw, lcd_e, lcd_7, lcd_6, lcd_5, lcd_4};
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
      samp_r   <= sync_r[SYNC_STAGES-1];
      prev_e_r <= samp_r[4];
    end
  end

  // Strobe detection, byte assembly, AC step and data-write window
  always_comb begin
    strobe_s = prev_e_r & ~samp_r[4];
    rs_s     = samp_r[6];
    rw_s     = samp_r[5];
    nib_s    = samp_r[3:0];
    if (four_bit_r) begin
      byte_s      = {hi_nib_r, nib_s};
      byte_done_s = strobe_s & ~rw_s & phase_lo_r;
    end else begin
      byte_s      = {nib_s, 4'h0};
      byte_done_s = strobe_s & ~rw_s;
    end
    ac_nx_s = ac_step(ac_r, id_r);
    if (ac_r[6:4] == 3'b000) begin
      in_win_s = 1'b1;
      idx_s    = {1'b0, ac_r[3:0]};
    end else if (ac_r[6:4] == 3'b100) begin
      in_win_s = 1'b1;
      idx_s    = {1'b1, ac_r[3:0]};
    end else begin
      in_win_s = 1'b0;
      idx_s    = 5'd0;
    end
    chars_wr_s = chars_r;
    for (int i = 0; i < 32; i++) begin
      if (in_win_s && (idx_s == 5'(i))) chars_wr_s[255-8*i -: 8] = byte_s;
      else                              chars_wr_s[255-8*i -: 8] = chars_r[255-8*i -: 8];
    end
  end

  // Nibble phase, byte output, instruction decode and DDRAM shadow update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chars_r      <= {32{CLEAR_CHAR}};
      byte_valid_r <= 1'b0;
      byte_out_r   <= 8'h00;
      byte_rs_r    <= 1'b0;
      four_bit_r   <= 1'b0;
      display_on_r <= 1'b0;
      ac_r         <= 7'h00;
      id_r         <= 1'b1;
      phase_lo_r   <= 1'b0;
      hi_nib_r     <= 4'h0;
    end else begin
      byte_valid_r <= byte_done_s;
      if (strobe_s && four_bit_r) begin
        if (!phase_lo_r) begin
          hi_nib_r   <= nib_s;
          phase_lo_r <= 1'b1;
        end else begin
          phase_lo_r <= 1'b0;
        end
      end
      if (byte_done_s) begin
        byte_out_r <= byte_s;
        byte_rs_r  <= rs_s;
        if (rs_s) begin
          chars_r <= chars_wr_s;
          ac_r    <= ac_nx_s;
        end else begin
          casez (byte_s)
            8'b1???????: ac_r <= byte_s[6:0];
            8'b01??????: begin end
            8'b001?????: begin
              four_bit_r <= ~byte_s[4];
              phase_lo_r <= 1'b0;
            end
            8'b0001????: begin end
            8'b00001???: display_on_r <= byte_s[2];
            8'b000001??: id_r <= byte_s[1];
            8'b0000001?: ac_r <= 7'h00;
            8'b00000001: begin
              chars_r <= {32{CLEAR_CHAR}};
              ac_r    <= 7'h00;
              id_r    <= 1'b1;
            end
            default: begin end
          endcase
        end
      end
    end
  end

  assign chars      = chars_r;
  assign byte_valid = byte_valid_r;
  assign byte_out   = byte_out_r;
  assign byte_rs    = byte_rs_r;
  assign four_bit   = four_bit_r;
  assign display_on = display_on_r;

`ifdef LCD_RX_STATS_EN
  logic [15:0] cmd_cnt_r;
  logic [15:0] data_cnt_r;

  // Saturating instruction/data byte counters, aligned with byte_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_cnt_r  <= 16'h0000;
      data_cnt_r <= 16'h0000;
    end else if (byte_done_s) begin
      if (rs_s) begin
        if (data_cnt_r != 16'hFFFF) data_cnt_r <= data_cnt_r + 16'd1;
      end else begin
        if (cmd_cnt_r != 16'hFFFF) cmd_cnt_r <= cmd_cnt_r + 16'd1;
      end
    end
  end

  assign cmd_count  = cmd_cnt_r;
  assign data_count = data_cnt_r;
`else
  assign cmd_count  = 16'h0000;
  assign data_count = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: drives nibble strobes on the LCD bus and compares
// outputs against hand-computed expectations.
module tb_lcd_bus_receiver;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
  logic         lcd_4 = 1'b0, lcd_5 = 1'b0, lcd_6 = 1'b0, lcd_7 = 1'b0;
  logic [255:0] chars;
  logic         byte_valid;
  logic [7:0]   byte_out;
  logic         byte_rs;
  logic         four_bit;
  logic         display_on;
  logic [15:0]  cmd_count;
  logic [15:0]  data_count;

  int n_cmp = 0;
  int n_bad = 0;
  int bv_count = 0;
  int exp_cmd = 0;
  int exp_data = 0;
  logic [255:0] exp_chars;

  lcd_bus_receiver #(.SYNC_STAGES(SYNC), .CLEAR_CHAR(8'h20)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd_4(lcd_4), .lcd_5(lcd_5), .lcd_6(lcd_6), .lcd_7(lcd_7),
    .chars(chars), .byte_valid(byte_valid), .byte_out(byte_out), .byte_rs(byte_rs),
    .four_bit(four_bit), .display_on(display_on), .cmd_count(cmd_count), .data_count(data_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (byte_valid) bv_count++;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_nib(input logic rs, input logic rw, input logic [3:0] nib, input logic want_byte);
    int n;
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = rw;
    {lcd_7, lcd_6, lcd_5, lcd_4} = nib;
    lcd_e = 1'b1;
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    if (want_byte) begin
      n = 0;
      do begin
        @(posedge clk);
        n++;
        @(negedge clk);
      end while (!byte_valid && n < 20);
      check("latency", n, SYNC + 2);
      repeat (3) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send8(input logic [3:0] nib);
    send_nib(1'b0, 1'b0, nib, 1'b1);
    exp_cmd++;
  endtask

  task automatic send4(input logic rs, input logic [7:0] b);
    send_nib(rs, 1'b0, b[7:4], 1'b0);
    send_nib(rs, 1'b0, b[3:0], 1'b1);
    if (rs) exp_data++;
    else    exp_cmd++;
  endtask

  task automatic check_stats();
`ifdef LCD_RX_STATS_EN
    check("cmd_count", cmd_count, exp_cmd);
    check("data_count", data_count, exp_data);
`else
    check("cmd_count", cmd_count, 16'h0000);
    check("data_count", data_count, 16'h0000);
`endif
  endtask

  initial begin
    repeat (3) @(negedge clk);
    exp_chars = {32{8'h20}};
    check("rst_chars", chars, exp_chars);
    check("rst_four_bit", four_bit, 1'b0);
    check("rst_display_on", display_on, 1'b0);
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_byte_out", byte_out, 8'h00);
    check("rst_byte_rs", byte_rs, 1'b0);
    check_stats();
    rst_n = 1'b1;

    // 8-bit init sequence into 4-bit mode
    for (int i = 0; i < 3; i++) begin
      send8(4'h3);
      check("init_byte_30", byte_out, 8'h30);
      check("init_still_8bit", four_bit, 1'b0);
    end
    send8(4'h2);
    check("init_byte_20", byte_out, 8'h20);
    check("init_four_bit", four_bit, 1'b1);
    check("init_bv_count", bv_count, 4);

    // 4-bit: display on, home address, "HC"
    send4(1'b0, 8'h0C);
    check("disp_on", display_on, 1'b1);
    send4(1'b0, 8'h80);
    send4(1'b1, 8'h48);
    check("byte_rs_data", byte_rs, 1'b1);
    send4(1'b1, 8'h43);
    exp_chars[255:240] = 16'h4843;
    check("chars_HC", chars[255:240], 16'h4843);
    check("bv_count_8", bv_count, 8);

    // Read strobes toggle phase without producing bytes
    send_nib(1'b0, 1'b1, 4'h0, 1'b0);
    send_nib(1'b0, 1'b1, 4'h0, 1'b0);
    check("read_no_byte", bv_count, 8);

    // Line 2 last cell, then past the window
    send4(1'b0, 8'hCF);
    check("byte_out_cf", byte_out, 8'hCF);
    send4(1'b1, 8'h41);
    exp_chars[7:0] = 8'h41;
    check("chars_A", chars[7:0], 8'h41);
    send4(1'b1, 8'h42);
    check("chars_B_outside", chars, exp_chars);

    // Decrement mode with 0x00 -> 0x67 wrap
    send4(1'b0, 8'h04);
    send4(1'b0, 8'h80);
    send4(1'b1, 8'h78);
    exp_chars[255:248] = 8'h78;
    check("chars_x", chars, exp_chars);
    send4(1'b1, 8'h79);
    check("chars_y_outside", chars, exp_chars);

    // Increment wrap 0x27 -> 0x40
    send4(1'b0, 8'h06);
    send4(1'b0, 8'hA7);
    send4(1'b1, 8'h70);
    check("chars_p_outside", chars, exp_chars);
    send4(1'b1, 8'h71);
    exp_chars[127:120] = 8'h71;
    check("chars_q_wrap", chars, exp_chars);

    // Display off, clear, return home
    send4(1'b0, 8'h08);
    check("disp_off", display_on, 1'b0);
    send4(1'b0, 8'h01);
    exp_chars = {32{8'h20}};
    check("clear_chars", chars, exp_chars);
    send4(1'b1, 8'h6B);
    exp_chars[255:248] = 8'h6B;
    check("chars_k", chars, exp_chars);
    send4(1'b0, 8'h02);
    send4(1'b1, 8'h6D);
    exp_chars[255:248] = 8'h6D;
    check("chars_home_m", chars, exp_chars);
    check_stats();

    // Reset between nibbles discards the HI nibble
    send_nib(1'b0, 1'b0, 4'hF, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_cmd = 0;
    exp_data = 0;
    check("rst2_four_bit", four_bit, 1'b0);
    check("rst2_chars", chars, {32{8'h20}});
    send8(4'h2);
    check("rst2_byte_out", byte_out, 8'h20);
    check("rst2_four_bit_set", four_bit, 1'b1);
    check_stats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
